// File: rtl/dii_mux_pkg.sv
// Shared types and grant encodings for the two-input packet-granular DII multiplexer.
package dii_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } dii_mux_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IN0  = 2'b01;
  localparam logic [1:0] GRANT_IN1  = 2'b10;

endpackage

// File: rtl/dii_reg_stage.sv
// One-entry registered DII slice: accepts whenever empty or draining, so a load
// and a drain in the same cycle sustain one flit per cycle.
module dii_reg_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic             last_reg;
  logic             load;

  assign in_ready = !valid_reg | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      last_reg  <= in_last;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;

endmodule

// File: rtl/dii_packet_mux.sv
// Two-input DII multiplexer that arbitrates only at packet boundaries and drives a
// registered output. Define OSD_DII_MUX_RR_EN for round-robin, else in0 has fixed priority.
module dii_packet_mux
  import dii_mux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant
);

  dii_mux_state_t   state_reg;
  logic [1:0]       sel;
  logic [1:0]       in_valid_vec;
  logic [1:0]       in_ready_vec;
  logic             slot_free;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
`ifdef OSD_DII_MUX_RR_EN
  logic             last_grant_reg;
`endif

  assign in_valid_vec = {in1_valid, in0_valid};

  // IDLE arbitration is combinational so the winner is accepted without a bubble.
  always_comb begin
    sel = GRANT_NONE;
    case (state_reg)
      GNT0: sel = GRANT_IN0;
      GNT1: sel = GRANT_IN1;
      default: begin
        if (in0_valid && in1_valid) begin
`ifdef OSD_DII_MUX_RR_EN
          sel = last_grant_reg ? GRANT_IN0 : GRANT_IN1;
`else
          sel = GRANT_IN0;
`endif
        end else if (in0_valid) begin
          sel = GRANT_IN0;
        end else if (in1_valid) begin
          sel = GRANT_IN1;
        end
      end
    endcase
    if (!rst_n) sel = GRANT_NONE;
  end

  assign sel_valid = |(sel & in_valid_vec);
  assign sel_data  = sel[1] ? in1_data : in0_data;
  assign sel_last  = sel[1] ? in1_last : in0_last;
  assign accept    = sel_valid & slot_free;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign in_ready_vec[gi] = sel[gi] & slot_free;
    end
  endgenerate

  assign in0_ready = in_ready_vec[0];
  assign in1_ready = in_ready_vec[1];
  assign grant     = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (accept) begin
      case (state_reg)
        IDLE:    if (!sel_last) state_reg <= sel[1] ? GNT1 : GNT0;
        default: if (sel_last) state_reg <= IDLE;
      endcase
    end
  end

`ifdef OSD_DII_MUX_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (accept && state_reg == IDLE) begin
      last_grant_reg <= sel[1];
    end
  end
`endif

  dii_reg_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (sel_valid),
    .in_data  (sel_data),
    .in_last  (sel_last),
    .in_ready (slot_free),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_dii_packet_mux.sv
// Directed bench for dii_packet_mux with a queue-based packet model checked every cycle.
module tb_dii_packet_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in0_valid = 1'b0;
  logic [15:0] in0_data = '0;
  logic        in0_last = 1'b0;
  logic        in0_ready;
  logic        in1_valid = 1'b0;
  logic [15:0] in1_data = '0;
  logic        in1_last = 1'b0;
  logic        in1_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [1:0]  grant;

  int tests = 0;
  int fails = 0;

  // Flits are {last, data}; log entries are the same value zero-extended to 32 bits.
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] m_q[$];
  logic [31:0] log_q[$];
  logic        hold0 = 1'b0;
  logic        acc0 = 1'b0;
  logic        acc1 = 1'b0;
  int          m_owner = -1;
  bit          m_lastg = 1'b1;

  always #5 clk = ~clk;

  dii_packet_mux #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_valid(in0_valid),
    .in0_data (in0_data),
    .in0_last (in0_last),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid),
    .in1_data (in1_data),
    .in1_last (in1_last),
    .in1_ready(in1_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .grant    (grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("log_count", log_q.size(), n);
  endtask

  task automatic exp_log(input int idx, input logic [31:0] v);
    chk($sformatf("log[%0d]", idx), (idx < log_q.size()) ? log_q[idx] : 32'hdead_beef, v);
  endtask

  // Upstream sources: present queue head, pop after a handshake seen at the prior negedge.
  always @(posedge clk) begin
    #2;
    if (acc0 && q0.size() > 0) q0.delete(0);
    if (acc1 && q1.size() > 0) q1.delete(0);
    in0_valid = (q0.size() > 0) && !hold0;
    {in0_last, in0_data} = (q0.size() > 0) ? q0[0] : 17'h0;
    in1_valid = (q1.size() > 0);
    {in1_last, in1_data} = (q1.size() > 0) ? q1[0] : 17'h0;
  end

  // Model: a packet owner, the arbitration rule, and a one-deep queue of flits in flight.
  always @(negedge clk) begin
    int          who;
    logic        ev;
    logic        slot;
    logic [16:0] f;
    logic [1:0]  eg;
    if (!rst_n) begin
      m_owner = -1;
      m_lastg = 1'b1;
      m_q.delete();
      acc0 = 1'b0;
      acc1 = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
    end else begin
      ev = (m_q.size() > 0);
      chk("cyc_out_valid", out_valid, ev);
      if (ev) begin
        chk("cyc_out_data", out_data, m_q[0][15:0]);
        chk("cyc_out_last", out_last, m_q[0][16]);
      end
      slot = !ev || out_ready;
      who = m_owner;
      if (who < 0) begin
        if (in0_valid && in1_valid) begin
`ifdef OSD_DII_MUX_RR_EN
          who = m_lastg ? 0 : 1;
`else
          who = 0;
`endif
        end else if (in0_valid) who = 0;
        else if (in1_valid) who = 1;
      end
      eg = (who == 0) ? 2'b01 : (who == 1) ? 2'b10 : 2'b00;
      chk("cyc_grant", grant, eg);
      chk("cyc_in0_ready", in0_ready, (who == 0) && slot);
      chk("cyc_in1_ready", in1_ready, (who == 1) && slot);
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      if (out_valid && out_ready) begin
        log_q.push_back({15'b0, out_last, out_data});
        $display("[TB] out data=%h last=%b t=%0t", out_data, out_last, $time);
      end
      if (ev && out_ready) m_q.delete(0);
      if (who >= 0 && slot && ((who == 0) ? in0_valid : in1_valid)) begin
        f = (who == 0) ? {in0_last, in0_data} : {in1_last, in1_data};
        m_q.push_back(f);
        if (m_owner < 0) begin
          m_lastg = (who == 1);
          if (!f[16]) m_owner = who;
        end else if (f[16]) begin
          m_owner = -1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_grant", grant, 0);
    rst_n = 1'b1;

    // Single-flit packet on in0
    step();
    log_q.delete();
    q0.push_back(17'h1_1234);
    #2;
    chk("t1_grant_pulse", grant, 2'b01);
    chk("t1_in0_ready", in0_ready, 1);
    step();
    #2;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 16'h1234);
    chk("t1_out_last", out_last, 1);
    chk("t1_grant_released", grant, 2'b00);
    wait_log(1, 10);
    exp_log(0, 32'h1_1234);

    // Three-flit packet on in0 with in1 waiting
    log_q.delete();
    q0.push_back(17'h0_00A0);
    q0.push_back(17'h0_00A1);
    q0.push_back(17'h1_00A2);
    step();
    q1.push_back(17'h1_00B0);
    #2;
    chk("t2_in1_blocked_a1", in1_ready, 0);
    chk("t2_grant_in0", grant, 2'b01);
    step();
    #2;
    chk("t2_in1_blocked_a2", in1_ready, 0);
    step();
    #2;
    chk("t2_in1_ready_after_last", in1_ready, 1);
    wait_log(4, 20);
    exp_log(0, 32'h0_00A0);
    exp_log(1, 32'h0_00A1);
    exp_log(2, 32'h1_00A2);
    exp_log(3, 32'h1_00B0);

    // Back-to-back single-flit packets on both inputs
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(17'h1_00C0 + 17'(i));
      q1.push_back(17'h1_00D0 + 17'(i));
    end
    wait_log(8, 40);
    for (int i = 0; i < 4; i++) begin
`ifdef OSD_DII_MUX_RR_EN
      exp_log(2 * i, 32'h1_00C0 + i);
      exp_log(2 * i + 1, 32'h1_00D0 + i);
`else
      exp_log(i, 32'h1_00C0 + i);
      exp_log(i + 4, 32'h1_00D0 + i);
`endif
    end

    // Output back-pressure for five cycles mid-packet
    log_q.delete();
    for (int i = 0; i < 4; i++) q0.push_back(((i == 3) ? 17'h1_0000 : 17'h0) | (17'h00E0 + 17'(i)));
    step();
    step();
    out_ready = 1'b0;
    q1.push_back(17'h1_00F0);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 16'h00E1);
      chk("t4_in0_ready", in0_ready, 0);
      chk("t4_in1_ready", in1_ready, 0);
      step();
    end
    out_ready = 1'b1;
    wait_log(5, 30);
    for (int i = 0; i < 4; i++) exp_log(i, ((i == 3) ? 32'h1_0000 : 32'h0) | (32'h00E0 + i));
    exp_log(4, 32'h1_00F0);

    // Reset after two of four flits, then a fresh packet on in1
    log_q.delete();
    for (int i = 0; i < 4; i++) q0.push_back(((i == 3) ? 17'h1_0000 : 17'h0) | (17'h0070 + 17'(i)));
    step();
    step();
    rst_n = 1'b0;
    q0.delete();
    #2;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_in0_ready", in0_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    q1.push_back(17'h0_0080);
    q1.push_back(17'h1_0081);
    wait_log(3, 20);
    exp_log(0, 32'h0_0070);
    exp_log(1, 32'h0_0080);
    exp_log(2, 32'h1_0081);

    // in0 granted but gapped; in1 must wait for the in0 last flit
    log_q.delete();
    q0.push_back(17'h0_0090);
    q0.push_back(17'h1_0091);
    step();
    hold0 = 1'b1;
    q1.push_back(17'h1_00B5);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t6_grant_held", grant, 2'b01);
      chk("t6_in1_blocked", in1_ready, 0);
      step();
    end
    hold0 = 1'b0;
    wait_log(3, 20);
    exp_log(0, 32'h0_0090);
    exp_log(1, 32'h1_0091);
    exp_log(2, 32'h1_00B5);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
